// File: rtl/alu_stream_ctrl.sv
// alu_stream_ctrl
//   Byte-stream sequencer for a combinational ALU. It collects three bytes in order
//   (operand A, operand B, opcode) and drives the registered ALU inputs. It then
//   captures ALU_RESULT and offers the captured value on a valid/ready output stream.
//
// Ports
//   CLK, RST_N             clock (posedge) and asynchronous active-low reset
//   RX_DATA/VALID/READY    incoming byte stream (byte taken on RX_VALID & RX_READY)
//   ALU_A, ALU_B, ALU_OP   registered ALU operands/opcode, hold last values
//   ALU_RESULT             combinational result returned by the ALU
//   TX_DATA/VALID/READY    captured result stream
//   BUSY                   high whenever a transaction is in progress
//   ERR_TIMEOUT            one-cycle pulse when the inter-byte timeout aborts a transaction
//
// Configuration
//   ALU_CTRL_TIMEOUT_EN    when defined, a transaction waiting in S_B or S_OP is aborted
//                          after TIMEOUT_CYCLES idle cycles. When undefined, the controller
//                          waits indefinitely and ERR_TIMEOUT stays 0.
module alu_stream_ctrl #(
  parameter int SIZEDATA       = 8,
  parameter int SIZEOP         = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [SIZEDATA-1:0] RX_DATA,
  input  logic                RX_VALID,
  output logic                RX_READY,
  output logic [SIZEDATA-1:0] ALU_A,
  output logic [SIZEDATA-1:0] ALU_B,
  output logic [SIZEOP-1:0]   ALU_OP,
  input  logic [SIZEDATA-1:0] ALU_RESULT,
  output logic [SIZEDATA-1:0] TX_DATA,
  output logic                TX_VALID,
  input  logic                TX_READY,
  output logic                BUSY,
  output logic                ERR_TIMEOUT
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SEND = 3'd4
  } state_t;

  state_t state, state_next;

  logic load_a, load_b, load_op;
  logic capture, release_tx;
  logic timeout_hit;
  logic tmo_expired;
  logic rx_take;

`ifdef ALU_CTRL_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_expired = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts idle cycles while waiting for B or the opcode. Any accepted byte restarts it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmo_cnt <= '0;
    end else if (state == S_A || rx_take || tmo_expired) begin
      tmo_cnt <= '0;
    end else if (state == S_B || state == S_OP) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_A;
    end else begin
      state <= state_next;
    end
  end

  // An accepted byte takes priority over timeout expiry in the same cycle.
  always_comb begin
    state_next  = state;
    RX_READY    = 1'b0;
    load_a      = 1'b0;
    load_b      = 1'b0;
    load_op     = 1'b0;
    capture     = 1'b0;
    release_tx  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_A: begin
        RX_READY = 1'b1;
        if (RX_VALID) begin
          load_a     = 1'b1;
          state_next = S_B;
        end
      end
      S_B: begin
        RX_READY = 1'b1;
        if (RX_VALID) begin
          load_b     = 1'b1;
          state_next = S_OP;
        end else if (tmo_expired) begin
          timeout_hit = 1'b1;
          state_next  = S_A;
        end
      end
      S_OP: begin
        RX_READY = 1'b1;
        if (RX_VALID) begin
          load_op    = 1'b1;
          state_next = S_EXEC;
        end else if (tmo_expired) begin
          timeout_hit = 1'b1;
          state_next  = S_A;
        end
      end
      S_EXEC: begin
        capture    = 1'b1;
        state_next = S_SEND;
      end
      S_SEND: begin
        if (TX_READY) begin
          release_tx = 1'b1;
          state_next = S_A;
        end
      end
      default: state_next = S_A;
    endcase
  end

  assign rx_take = RX_VALID & RX_READY;
  assign BUSY    = (state != S_A);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ALU_A       <= '0;
      ALU_B       <= '0;
      ALU_OP      <= '0;
      TX_DATA     <= '0;
      TX_VALID    <= 1'b0;
      ERR_TIMEOUT <= 1'b0;
    end else begin
      if (load_a)  ALU_A  <= RX_DATA;
      if (load_b)  ALU_B  <= RX_DATA;
      if (load_op) ALU_OP <= RX_DATA[SIZEOP-1:0];
      if (capture) begin
        TX_DATA  <= ALU_RESULT;
        TX_VALID <= 1'b1;
      end else if (release_tx) begin
        TX_VALID <= 1'b0;
      end
      ERR_TIMEOUT <= timeout_hit;
    end
  end

endmodule

// File: tb/tb_alu_stream_ctrl.sv
// tb_alu_stream_ctrl
//   Randomized and directed bench for alu_stream_ctrl. The bench provides a small
//   combinational ALU in the environment. Expected results are derived from the bytes
//   the bench sends. Compile with ALU_CTRL_TIMEOUT_EN defined to cover the timeout feature.
module tb_alu_stream_ctrl;

  localparam int TMO = 8;

  logic       CLK;
  logic       RST_N;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic [7:0] ALU_A;
  logic [7:0] ALU_B;
  logic [5:0] ALU_OP;
  logic [7:0] ALU_RESULT;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic       BUSY;
  logic       ERR_TIMEOUT;

  int n_tests = 0;
  int n_fail  = 0;

  alu_stream_ctrl #(
    .SIZEDATA       (8),
    .SIZEOP         (6),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .RX_DATA     (RX_DATA),
    .RX_VALID    (RX_VALID),
    .RX_READY    (RX_READY),
    .ALU_A       (ALU_A),
    .ALU_B       (ALU_B),
    .ALU_OP      (ALU_OP),
    .ALU_RESULT  (ALU_RESULT),
    .TX_DATA     (TX_DATA),
    .TX_VALID    (TX_VALID),
    .TX_READY    (TX_READY),
    .BUSY        (BUSY),
    .ERR_TIMEOUT (ERR_TIMEOUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return 8'(a + b);
      6'h22:   return 8'(a - b);
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return b >> a[2:0];
      6'h03:   return 8'($signed(b) >>> a[2:0]);
      default: return 8'h00;
    endcase
  endfunction

  // Environment ALU fed by the controller outputs.
  always_comb ALU_RESULT = alu_ref(ALU_A, ALU_B, ALU_OP);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) tick();
    RX_DATA  = b;
    RX_VALID = 1'b1;
    n = 0;
    while (!RX_READY && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check_eq("rx_ready_wait", 32'(RX_READY), 32'd1);
    tick();
    RX_VALID = 1'b0;
  endtask

  // Called one cycle after the opcode edge. Result must appear after the following edge.
  task automatic finish_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input int bp);
    logic [7:0] exp;
    exp = alu_ref(a, b, op[5:0]);
    check_eq("tx_valid_n1", 32'(TX_VALID), 32'd0);
    check_eq("busy_exec", 32'(BUSY), 32'd1);
    tick();
    check_eq("tx_valid_n2", 32'(TX_VALID), 32'd1);
    check_eq("tx_data", 32'(TX_DATA), 32'(exp));
    check_eq("alu_a", 32'(ALU_A), 32'(a));
    check_eq("alu_b", 32'(ALU_B), 32'(b));
    check_eq("alu_op", 32'(ALU_OP), 32'(op[5:0]));
    check_eq("rx_ready_send", 32'(RX_READY), 32'd0);
    if (bp > 0) begin
      TX_READY = 1'b0;
      repeat (bp) begin
        tick();
        check_eq("bp_valid", 32'(TX_VALID), 32'd1);
        check_eq("bp_data", 32'(TX_DATA), 32'(exp));
      end
      TX_READY = 1'b1;
    end
    tick();
    check_eq("tx_valid_done", 32'(TX_VALID), 32'd0);
    check_eq("busy_done", 32'(BUSY), 32'd0);
    check_eq("rx_ready_done", 32'(RX_READY), 32'd1);
    check_eq("err_none", 32'(ERR_TIMEOUT), 32'd0);
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input int gap, input int bp);
    send_byte(a, gap);
    send_byte(b, gap);
    send_byte(op, gap);
    finish_txn(a, b, op, bp);
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [7:0] ra, rb, rop;
    ops[0] = 6'h20; ops[1] = 6'h22; ops[2] = 6'h24; ops[3] = 6'h25;
    ops[4] = 6'h26; ops[5] = 6'h27; ops[6] = 6'h02; ops[7] = 6'h03;

    RST_N    = 1'b0;
    RX_DATA  = 8'h00;
    RX_VALID = 1'b0;
    TX_READY = 1'b1;

    #3;
    check_eq("rst_alu_a", 32'(ALU_A), 32'd0);
    check_eq("rst_alu_b", 32'(ALU_B), 32'd0);
    check_eq("rst_alu_op", 32'(ALU_OP), 32'd0);
    check_eq("rst_tx_data", 32'(TX_DATA), 32'd0);
    check_eq("rst_tx_valid", 32'(TX_VALID), 32'd0);
    check_eq("rst_err", 32'(ERR_TIMEOUT), 32'd0);
    check_eq("rst_rx_ready", 32'(RX_READY), 32'd1);
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();

    // ADD 5 + 3
    run_txn(8'h05, 8'h03, 8'h20, 0, 0);

    // Backpressure with the next A byte held on the input
    send_byte(8'h05, 0);
    send_byte(8'h03, 0);
    send_byte(8'h20, 0);
    check_eq("bp3_n1", 32'(TX_VALID), 32'd0);
    tick();
    check_eq("bp3_rise", 32'(TX_VALID), 32'd1);
    TX_READY = 1'b0;
    RX_DATA  = 8'h11;
    RX_VALID = 1'b1;
    repeat (10) begin
      tick();
      check_eq("bp3_valid", 32'(TX_VALID), 32'd1);
      check_eq("bp3_data", 32'(TX_DATA), 32'h08);
      check_eq("bp3_rx_ready", 32'(RX_READY), 32'd0);
      check_eq("bp3_a_held", 32'(ALU_A), 32'h05);
    end
    TX_READY = 1'b1;
    tick();
    check_eq("bp3_released", 32'(TX_VALID), 32'd0);
    check_eq("bp3_rx_ready", 32'(RX_READY), 32'd1);
    run_txn(8'h11, 8'h04, 8'h22, 0, 0);

    // Opcode upper bits dropped
    run_txn(8'h40, 8'h09, 8'hE0, 1, 2);
    check_eq("op_trunc", 32'(ALU_OP), 32'h20);

`ifdef ALU_CTRL_TIMEOUT_EN
    // Lone A byte, then idle: abort after TMO cycles in S_B
    send_byte(8'h07, 0);
    for (int k = 1; k <= TMO + 1; k++) begin
      tick();
      check_eq("tmo_pulse", 32'(ERR_TIMEOUT), 32'(k == TMO));
      check_eq("tmo_busy", 32'(BUSY), 32'(k < TMO));
    end
    check_eq("tmo_a_kept", 32'(ALU_A), 32'h07);
    run_txn(8'h02, 8'h02, 8'h20, 0, 0);

    // B byte presented exactly on the expiry cycle wins
    send_byte(8'h09, 0);
    repeat (TMO - 1) tick();
    check_eq("exp_no_pulse_pre", 32'(ERR_TIMEOUT), 32'd0);
    RX_DATA  = 8'h06;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    check_eq("exp_no_pulse", 32'(ERR_TIMEOUT), 32'd0);
    check_eq("exp_busy", 32'(BUSY), 32'd1);
    check_eq("exp_b", 32'(ALU_B), 32'h06);
    send_byte(8'h22, 2);
    finish_txn(8'h09, 8'h06, 8'h22, 0);
`else
    // Without the timeout the controller waits indefinitely in S_B
    send_byte(8'h07, 0);
    repeat (3 * TMO) begin
      tick();
      check_eq("wait_busy", 32'(BUSY), 32'd1);
      check_eq("wait_err", 32'(ERR_TIMEOUT), 32'd0);
    end
    send_byte(8'h02, 0);
    send_byte(8'h20, 0);
    finish_txn(8'h07, 8'h02, 8'h20, 0);
`endif

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]};
      run_txn(ra, rb, rop, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset asserted mid-cycle while a result is pending in S_SEND
    send_byte(8'h30, 0);
    send_byte(8'h0C, 0);
    send_byte(8'h24, 0);
    TX_READY = 1'b0;
    tick();
    check_eq("send_valid", 32'(TX_VALID), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check_eq("rst6_tx_valid", 32'(TX_VALID), 32'd0);
    check_eq("rst6_tx_data", 32'(TX_DATA), 32'd0);
    check_eq("rst6_alu_a", 32'(ALU_A), 32'd0);
    check_eq("rst6_busy", 32'(BUSY), 32'd0);
    check_eq("rst6_rx_ready", 32'(RX_READY), 32'd1);
    TX_READY = 1'b1;
    @(negedge CLK);
    RST_N = 1'b1;
    tick();

    // Reset after a partial transaction discards the collected byte
    send_byte(8'h33, 0);
    check_eq("partial_busy", 32'(BUSY), 32'd1);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_eq("partial_rst_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    run_txn(8'h0A, 8'h05, 8'h22, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
